magnitude_comparator_pipe: RTL and testbench

MAGNITUDE_COMPARATOR_PIPE -- requirements
Module: magnitude_comparator_pipe

---
 rtl/magnitude_comparator_pipe.sv | 104 ++++++++++
 tb/tb_magnitude_comparator_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/magnitude_comparator_pipe.sv
// rtl/magnitude_comparator_pipe.sv - pipelined signed/unsigned magnitude comparator
// Resolves CHUNK bits per stage, LSB chunk first; a differing higher chunk overrides lower verdicts.
module magnitude_comparator_pipe #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gr,
  output logic             lt,
  output logic             eq,
  output logic [TAGW-1:0]  out_tag
);

  localparam int NSTAGE = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW     = NSTAGE * CHUNK;

  typedef struct packed {
    logic            v;
    logic            g;
    logic            l;
    logic [TAGW-1:0] t;
    logic [PW-1:0]   a;
    logic [PW-1:0]   b;
  } stage_t;

  stage_t r_stg [NSTAGE];
  stage_t w_nxt [NSTAGE];
  stage_t w_in;
  logic   r_up;
  logic   w_stall;

  function automatic stage_t step(input stage_t s, input int k);
    stage_t          o;
    logic [CHUNK-1:0] ca;
    logic [CHUNK-1:0] cb;
    o  = s;
    ca = s.a[k*CHUNK +: CHUNK];
    cb = s.b[k*CHUNK +: CHUNK];
    if (ca != cb) begin
      o.g = (ca > cb);
      o.l = (ca < cb);
    end
    return o;
  endfunction

  assign w_stall  = r_stg[NSTAGE-1].v & ~out_ready;
  assign in_ready = r_up & ~w_stall & ~flush;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    w_in              = '0;
    w_in.v            = in_valid & in_ready;
    w_in.t            = in_tag;
    w_in.a            = PW'(in_a);
    w_in.b            = PW'(in_b);
    w_in.a[WIDTH-1]   = in_a[WIDTH-1] ^ in_signed;
    w_in.b[WIDTH-1]   = in_b[WIDTH-1] ^ in_signed;
  end

  always_comb begin
    w_nxt[0] = step(w_in, 0);
    for (int k = 1; k < NSTAGE; k++) begin
      w_nxt[k] = step(r_stg[k-1], k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_up <= 1'b0;
      for (int k = 0; k < NSTAGE; k++) begin
        r_stg[k] <= '0;
      end
    end else begin
      r_up <= 1'b1;
      if (flush) begin
        for (int k = 0; k < NSTAGE; k++) begin
          r_stg[k].v <= 1'b0;
        end
      end else if (!w_stall) begin
        for (int k = 0; k < NSTAGE; k++) begin
          r_stg[k] <= w_nxt[k];
        end
      end
    end
  end

  assign out_valid = r_stg[NSTAGE-1].v;
  assign gr        = out_valid & r_stg[NSTAGE-1].g;
  assign lt        = out_valid & r_stg[NSTAGE-1].l;
  assign eq        = out_valid & ~r_stg[NSTAGE-1].g & ~r_stg[NSTAGE-1].l;
  assign out_tag   = out_valid ? r_stg[NSTAGE-1].t : '0;

endmodule

// File: tb/tb_magnitude_comparator_pipe.sv
// tb/tb_magnitude_comparator_pipe.sv - directed and streamed checks for magnitude_comparator_pipe
module tb_magnitude_comparator_pipe;

  localparam int W  = 32;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_signed = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          gr, lt, eq;
  logic [TW-1:0] out_tag;

  int total = 0;
  int bad   = 0;
  int n_acc = 0;

  logic [W-1:0]  va [64];
  logic [W-1:0]  vb [64];
  logic          vs [64];
  logic [TW-1:0] vt [64];

  magnitude_comparator_pipe #(.WIDTH(W), .CHUNK(8), .TAGW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .gr(gr), .lt(lt), .eq(eq), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (in_valid && in_ready) n_acc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic g, l;
    if (s) begin
      g = $signed(a) > $signed(b);
      l = $signed(a) < $signed(b);
    end else begin
      g = a > b;
      l = a < b;
    end
    return {g, l, ~g & ~l};
  endfunction

  task automatic send1(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic [TW-1:0] t, input logic [2:0] exp);
    @(negedge clk);
    in_a = a; in_b = b; in_signed = s; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({name, "_rdy"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({name, "_early1"}, out_valid, 0);
    repeat (2) @(negedge clk);
    chk({name, "_early3"}, out_valid, 0);
    @(negedge clk);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_res"}, {gr, lt, eq}, exp);
    chk({name, "_tag"}, out_tag, t);
  endtask

  task automatic run_stream(input string name, input int n, input int mode);
    int base, rx, cyc, tx;
    logic was_stall;
    logic [TW-1:0] h_tag;
    logic [2:0] h_res;
    base = n_acc; rx = 0; cyc = 0; was_stall = 1'b0; h_tag = '0; h_res = '0;
    while (rx < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (was_stall) begin
        chk({name, "_hold_v"}, out_valid, 1);
        chk({name, "_hold_tag"}, out_tag, h_tag);
        chk({name, "_hold_res"}, {gr, lt, eq}, h_res);
      end
      if (mode == 0) out_ready = (cyc >= 2 && cyc < 14) ? 1'b0 : 1'b1;
      else           out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && !out_ready) chk({name, "_stall_rdy"}, in_ready, 0);
      if (out_valid && out_ready) begin
        chk({name, "_tag"}, out_tag, vt[rx]);
        chk({name, "_res"}, {gr, lt, eq}, ref_cmp(va[rx], vb[rx], vs[rx]));
        rx++;
      end
      was_stall = out_valid && !out_ready;
      h_tag = out_tag;
      h_res = {gr, lt, eq};
      tx = n_acc - base;
      if (tx < n) begin
        in_a = va[tx]; in_b = vb[tx]; in_signed = vs[tx]; in_tag = vt[tx]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    chk({name, "_count"}, rx, n);
    chk({name, "_acc"}, n_acc - base, n);
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int base;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_res", {gr, lt, eq}, 3'b000);
    chk("rst_tag", out_tag, 0);
    chk("rst_rdy", in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_rdy_pre", in_ready, 0);
    @(negedge clk);
    chk("rel_rdy_post", in_ready, 1);

    send1("u_lt",   32'h0000_0001, 32'h8000_0000, 1'b0, 4'd3, 3'b010);
    send1("s_gr",   32'h0000_0001, 32'h8000_0000, 1'b1, 4'd4, 3'b100);
    send1("u_eq",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd5, 3'b001);
    send1("s_min",  32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 4'd6, 3'b010);
    send1("stg1",   32'h0000_0100, 32'h0000_00FF, 1'b0, 4'd7, 3'b100);
    send1("s_neg",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 4'd8, 3'b010);

    for (int i = 0; i < 6; i++) begin
      va[i] = 32'(i * 100); vb[i] = 32'd250; vs[i] = i[0]; vt[i] = 4'(i + 1);
    end
    run_stream("bp", 6, 0);

    @(negedge clk);
    base = n_acc;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_a = 32'(i); in_b = 32'd1; in_signed = 1'b0; in_tag = 4'(8 + i); in_valid = 1'b1;
      @(negedge clk);
    end
    chk("fl_full", out_valid, 1);
    chk("fl_acc4", n_acc - base, 4);
    flush = 1'b1; in_tag = 4'hF;
    #1 chk("fl_rdy", in_ready, 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_clear", out_valid, 0);
    chk("fl_noacc", n_acc - base, 4);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("fl_nostale", out_valid, 0);
    end

    @(negedge clk);
    in_a = 32'd9; in_b = 32'd2; in_signed = 1'b0; in_tag = 4'd1; in_valid = 1'b1;
    @(negedge clk);
    in_tag = 4'd2;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("ar_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_res", {gr, lt, eq}, 3'b000);
    chk("ar_tag", out_tag, 0);
    chk("ar_rdy", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ar_nostale", out_valid, 0);
    end
    send1("ar_eq", 32'd5, 32'd5, 1'b0, 4'd9, 3'b001);

    for (int i = 0; i < 48; i++) begin
      va[i] = $urandom;
      case ($urandom_range(0, 3))
        0: vb[i] = va[i];
        1: vb[i] = va[i] ^ (32'd1 << $urandom_range(0, 31));
        default: vb[i] = $urandom;
      endcase
      vs[i] = 1'($urandom_range(0, 1));
      vt[i] = 4'(i);
    end
    run_stream("rnd", 48, 1);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
